i_ddr_deser: RTL and testbench

DDR input capture and deserializer. Samples one serial pin on both edges of C, presents each captured bit pair per cycle, and assembles the bit stream into WIDTH-bit words with a one-cycle valid strobe. Runtime bit-level alignment is done with a BITSLIP request. It sits between the input buffer (or input delay) of a source-synchronous data pin and fabric logic. It is the receive-side counterpart of the DDR output register.

---
 rtl/i_ddr_deser_if.sv | 22 ++
 rtl/i_ddr_deser.sv | 114 +++++++++++
 tb/tb_i_ddr_deser.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i_ddr_deser_if.sv
// i_ddr_deser_if: serial pin, enable and bitslip in; captured pair,
// assembled word and word strobe out. master drives D/E/BITSLIP.
interface i_ddr_deser_if #(
  parameter int WIDTH = 4
);
  logic             D;
  logic             E;
  logic             BITSLIP;
  logic [1:0]       Q2;
  logic [WIDTH-1:0] Q;
  logic             DV;

  modport master (
    output D, E, BITSLIP,
    input  Q2, Q, DV
  );

  modport slave (
    input  D, E, BITSLIP,
    output Q2, Q, DV
  );
endinterface

// File: rtl/i_ddr_deser.sv
// i_ddr_deser: DDR input capture + WIDTH-bit deserializer with bitslip.
// Ports: C clock, R sync active-low reset, io (slave) D/E/BITSLIP/Q2/Q/DV.
module i_ddr_deser #(
  parameter int WIDTH = 4
) (
  input logic         C,
  input logic         R,
  i_ddr_deser_if.slave io
);

  typedef logic signed [5:0] cnt_t;

  logic             r_q;
  logic             f_q;
  logic             e_q;
  logic             v_q;
  logic             slip_q;
  logic             g1_q;
  logic             g2_q;
  logic [WIDTH-1:0] hist_q;
  logic [WIDTH-1:0] hist_d;
  logic [WIDTH-1:0] wd_q;
  logic [WIDTH-1:0] wd_d;
  cnt_t             n_q;
  cnt_t             n_d;
  logic             done_q;
  logic             done_d;
  logic [1:0]       q2_q;
  logic [WIDTH-1:0] q_q;
  logic             dv_q;
  logic             acc;
  logic [WIDTH:0]   h;

  // A slip is taken only if none was taken on the two previous edges.
  assign acc = io.BITSLIP & io.E & ~g1_q & ~g2_q;

  // n_q: bits held of the word in progress; -1 means the next
  // incoming bit is dropped (slip landed on an empty word).
  always_comb begin
    h      = {f_q, r_q, hist_q[WIDTH-1:1]};
    hist_d = h[WIDTH:1];
    wd_d   = wd_q;
    done_d = 1'b0;
    n_d    = n_q + cnt_t'(2);
    if (n_d == cnt_t'(WIDTH)) begin
      done_d = 1'b1;
      wd_d   = h[WIDTH:1];
      n_d    = '0;
    end else if (n_d == cnt_t'(WIDTH + 1)) begin
      // word ended on the rising bit; falling bit opens the next
      done_d = 1'b1;
      wd_d   = h[WIDTH-1:0];
      n_d    = cnt_t'(1);
    end
    if (slip_q) begin
      n_d = n_d - cnt_t'(1);
    end
  end

  always_ff @(posedge C) begin
    if (!R) begin
      r_q    <= 1'b0;
      e_q    <= 1'b0;
      v_q    <= 1'b0;
      slip_q <= 1'b0;
      g1_q   <= 1'b0;
      g2_q   <= 1'b0;
      hist_q <= '0;
      wd_q   <= '0;
      n_q    <= '0;
      done_q <= 1'b0;
      q2_q   <= 2'b00;
      q_q    <= '0;
      dv_q   <= 1'b0;
    end else begin
      e_q  <= io.E;
      g1_q <= acc;
      g2_q <= g1_q;
      dv_q <= 1'b0;
      if (io.E) begin
        r_q    <= io.D;
        v_q    <= 1'b1;
        slip_q <= acc;
        dv_q   <= done_q;
        done_q <= 1'b0;
        if (done_q) begin
          q_q <= wd_q;
        end
        // v_q: the previous enabled edge supplied a real pair
        if (v_q) begin
          q2_q   <= {f_q, r_q};
          hist_q <= hist_d;
          n_q    <= n_d;
          done_q <= done_d;
          wd_q   <= wd_d;
        end
      end
    end
  end

  // Falling bit is kept only for pairs whose rising edge was enabled.
  always_ff @(negedge C) begin
    if (!R) begin
      f_q <= 1'b0;
    end else if (e_q) begin
      f_q <= io.D;
    end
  end

  assign io.Q2 = q2_q;
  assign io.Q  = q_q;
  assign io.DV = dv_q;

endmodule

// File: tb/tb_i_ddr_deser.sv
// tb_i_ddr_deser: directed tests for i_ddr_deser at WIDTH 4 and 8.
// Both DUTs share C/R and stimulus; each task checks the relevant one.
module tb_i_ddr_deser;

  logic C = 1'b0;
  logic R = 1'b0;
  int   errs = 0;
  int   checks = 0;

  logic [1:0] q2_4;
  logic [1:0] q2_8;
  logic [3:0] q_4;
  logic [7:0] q_8;
  logic       dv_4;
  logic       dv_8;

  i_ddr_deser_if #(.WIDTH(4)) if4 ();
  i_ddr_deser_if #(.WIDTH(8)) if8 ();

  i_ddr_deser #(.WIDTH(4)) u4 (.C(C), .R(R), .io(if4));
  i_ddr_deser #(.WIDTH(8)) u8 (.C(C), .R(R), .io(if8));

  always #5 C = ~C;

  task automatic step(input logic r, input logic f,
                      input logic e, input logic s);
    if4.D = r;
    if4.E = e;
    if4.BITSLIP = s;
    if8.D = r;
    if8.E = e;
    if8.BITSLIP = s;
    @(posedge C);
    #1;
    q2_4 = if4.Q2;
    q_4  = if4.Q;
    dv_4 = if4.DV;
    q2_8 = if8.Q2;
    q_8  = if8.Q;
    dv_8 = if8.DV;
    if4.D = f;
    if8.D = f;
    @(negedge C);
    #1;
  endtask

  task automatic do_reset();
    R = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
    R = 1'b1;
  endtask

  function automatic logic cb(input int n);
    logic [7:0] w;
    w = 8'(n / 8 + 1);
    return w[n % 8];
  endfunction

  task automatic test_reset();
    R = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(i[0], ~i[0], 1'b1, 1'b0);
      checks++;
      if (q2_4 !== 2'b00 || q_4 !== 4'h0 || dv_4 !== 1'b0) begin
        errs++;
        $display("FAIL reset4 %0d: q2=%b q=%h dv=%b want 0", i,
                 q2_4, q_4, dv_4);
      end
      checks++;
      if (q2_8 !== 2'b00 || q_8 !== 8'h0 || dv_8 !== 1'b0) begin
        errs++;
        $display("FAIL reset8 %0d: q2=%b q=%h dv=%b want 0", i,
                 q2_8, q_8, dv_8);
      end
    end
    R = 1'b1;
    for (int k = 0; k < 2; k++) begin
      logic [1:0] eq2;
      eq2 = (k == 0) ? 2'b00 : 2'b01;
      step(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (dv_4 !== 1'b0 || dv_8 !== 1'b0) begin
        errs++;
        $display("FAIL rel_dv %0d: dv4=%b dv8=%b want 0", k, dv_4, dv_8);
      end
      checks++;
      if (q2_4 !== eq2 || q2_8 !== eq2) begin
        errs++;
        $display("FAIL rel_q2 %0d: q2_4=%b q2_8=%b want %b", k,
                 q2_4, q2_8, eq2);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      logic [1:0] eq2;
      logic       edv;
      logic [3:0] eq;
      eq2 = (k >= 1) ? 2'b01 : 2'b00;
      edv = (k >= 3) && (k % 2 == 1);
      eq  = (k >= 3) ? 4'b0101 : 4'b0000;
      step(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (q2_4 !== eq2 || dv_4 !== edv || q_4 !== eq) begin
        errs++;
        $display("FAIL basic e%0d: q2=%b dv=%b q=%b want %b %b %b",
                 k, q2_4, dv_4, q_4, eq2, edv, eq);
      end
    end
  endtask

  task automatic test_bitslip(input int sk);
    do_reset();
    for (int k = 0; k < 13; k++) begin
      logic       edv;
      logic [3:0] eq;
      edv = (k == 3 || k == 5 || k == 8 || k == 10 || k == 12);
      eq  = (k < 3) ? 4'b0000 : (k < 8) ? 4'b0101 : 4'b1010;
      step(1'b1, 1'b0, 1'b1, k == sk);
      checks++;
      if (dv_4 !== edv || q_4 !== eq) begin
        errs++;
        $display("FAIL slip%0d e%0d: dv=%b q=%b want %b %b",
                 sk, k, dv_4, q_4, edv, eq);
      end
    end
  endtask

  task automatic test_slip_guard();
    logic [63:0] pat;
    logic        req[20];
    logic        acc[20];
    logic        edv[24];
    logic [3:0]  eq[24];
    logic        mq[$];
    int          skip;
    pat  = 64'hC3A5_96F0_1E2D_7B48;
    skip = 0;
    for (int k = 0; k < 24; k++) begin
      edv[k] = 1'b0;
      eq[k]  = 4'h0;
    end
    for (int k = 0; k < 20; k++) begin
      req[k] = (k >= 2 && k <= 4) || (k >= 7 && k <= 10);
      acc[k] = req[k] && !(k >= 1 && acc[k-1]) && !(k >= 2 && acc[k-2]);
    end
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 2; j++) begin
        if (skip != 0) begin
          skip = 0;
        end else begin
          mq.push_back(pat[2*k+j]);
        end
        if (mq.size() == 4) begin
          edv[k+2] = 1'b1;
          eq[k+2]  = {mq[3], mq[2], mq[1], mq[0]};
          mq.delete();
        end
      end
      if (acc[k]) begin
        if (mq.size() > 0) begin
          void'(mq.pop_front());
        end else begin
          skip = 1;
        end
      end
    end
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(pat[2*k], pat[2*k+1], 1'b1, req[k]);
      checks++;
      if (dv_4 !== edv[k]) begin
        errs++;
        $display("FAIL guard_dv e%0d: dv=%b want %b", k, dv_4, edv[k]);
      end
      if (edv[k]) begin
        checks++;
        if (q_4 !== eq[k]) begin
          errs++;
          $display("FAIL guard_q e%0d: q=%b want %b", k, q_4, eq[k]);
        end
      end
    end
  endtask

  task automatic test_enable_gap();
    int p;
    p = 0;
    do_reset();
    for (int a = 0; a < 15; a++) begin
      logic       edv;
      logic [7:0] eq;
      edv = (a == 5 || a == 10 || a == 14);
      eq  = (a < 5) ? 8'h00 : (a < 10) ? 8'h01 :
            (a < 14) ? 8'h02 : 8'h03;
      if (a == 6) begin
        step(1'b1, 1'b1, 1'b0, 1'b0);
      end else begin
        step(cb(2*p), cb(2*p+1), 1'b1, 1'b0);
        p++;
      end
      checks++;
      if (dv_8 !== edv || q_8 !== eq) begin
        errs++;
        $display("FAIL gap e%0d: dv=%b q=%h want %b %h",
                 a, dv_8, q_8, edv, eq);
      end
      if (a == 1 || a == 6 || a == 7) begin
        logic [1:0] eq2;
        eq2 = (a == 1) ? 2'b01 : (a == 6) ? 2'b10 : 2'b00;
        checks++;
        if (q2_8 !== eq2) begin
          errs++;
          $display("FAIL gap_q2 e%0d: q2=%b want %b", a, q2_8, eq2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] pw;
    pw = 16'h5AA5;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(cb(2*k), cb(2*k+1), 1'b1, 1'b0);
    end
    R = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (q2_8 !== 2'b00 || q_8 !== 8'h00 || dv_8 !== 1'b0) begin
      errs++;
      $display("FAIL mid_rst: q2=%b q=%h dv=%b want 0", q2_8, q_8, dv_8);
    end
    R = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic       edv;
      logic [7:0] eq;
      edv = (k == 5);
      eq  = (k >= 5) ? 8'hA5 : 8'h00;
      step(pw[2*k], pw[2*k+1], 1'b1, 1'b0);
      checks++;
      if (dv_8 !== edv || q_8 !== eq) begin
        errs++;
        $display("FAIL mid e%0d: dv=%b q=%h want %b %h",
                 k, dv_8, q_8, edv, eq);
      end
    end
  endtask

  initial begin
    if4.D = 1'b0;
    if4.E = 1'b0;
    if4.BITSLIP = 1'b0;
    if8.D = 1'b0;
    if8.E = 1'b0;
    if8.BITSLIP = 1'b0;
    test_reset();
    test_basic();
    test_bitslip(4);
    test_bitslip(3);
    test_slip_guard();
    test_enable_gap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
